// File: rtl/spi_command_sequencer.sv
// spi_command_sequencer: SPI command frames to shadow/live control registers, status read-back and link watchdog; CTRL_READBACK_EN adds ctrl read-back opcodes 9/10
module spi_command_sequencer #(
  parameter int WD_CYCLES = 1000000,
  parameter int WD_W = 20
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] rx_data,
  input  logic        rx_valid,
  input  logic        tx_busy,
  input  logic [31:0] status_reg,
  output logic [15:0] tx_data,
  output logic        tx_load,
  output logic [31:0] ctrl_reg,
  output logic        ctrl_update,
  output logic [7:0]  err_count,
  output logic        wd_expired
);
  typedef enum logic [1:0] {IDLE, DECODE, TX_WAIT, TX_LOAD} state_t;
  state_t r_state, w_next;
  logic [15:0] r_frame, r_tx_data, w_rd_data;
  logic [31:0] r_shadow, r_ctrl;
  logic [7:0] r_err;
  logic [WD_W-1:0] r_wd_cnt;
  logic [3:0] w_op;
  logic [8:0] w_err_sum;
  logic r_ctrl_update, r_wd_exp, w_dec, w_read, w_illegal, w_commit, w_overrun, w_trip, w_unused;
  assign w_op = r_frame[15:12];
  assign w_dec = r_state == DECODE;
`ifdef CTRL_READBACK_EN
  assign w_read = w_op == 4'h1 || w_op == 4'h8 || w_op == 4'h9 || w_op == 4'hA;
  assign w_illegal = w_dec && w_op > 4'hA;
  assign w_rd_data = w_op == 4'h1 ? {4'h1, status_reg[11:0]} :
                     w_op == 4'h8 ? {4'h8, status_reg[23:12]} :
                     w_op == 4'h9 ? {4'h9, r_ctrl[11:0]} : {4'hA, r_ctrl[31:20]};
`else
  assign w_read = w_op == 4'h1 || w_op == 4'h8;
  assign w_illegal = w_dec && w_op > 4'h8;
  assign w_rd_data = w_op == 4'h1 ? {4'h1, status_reg[11:0]} : {4'h8, status_reg[23:12]};
`endif
  assign w_commit = w_dec && w_op == 4'h7;
  assign w_overrun = rx_valid && r_state != IDLE;
  // a commit in the same cycle reloads the counter, so it always beats a trip
  assign w_trip = WD_CYCLES != 0 && !rx_valid && !w_commit && r_wd_cnt == WD_W'(WD_CYCLES - 1);
  assign w_err_sum = {1'b0, r_err} + {8'b0, w_illegal} + {8'b0, w_overrun};
  assign w_unused = &{1'b0, status_reg[31:24]};
  assign tx_data = r_tx_data;
  assign tx_load = r_state == TX_LOAD;
  assign ctrl_reg = r_ctrl;
  assign ctrl_update = r_ctrl_update;
  assign err_count = r_err;
  assign wd_expired = r_wd_exp;
  // state register
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else r_state <= w_next;
  end
  // next-state: reads wait for the SPI core to go idle before the load pulse
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = rx_valid ? DECODE : IDLE;
      DECODE:  w_next = w_read ? TX_WAIT : IDLE;
      TX_WAIT: w_next = tx_busy ? TX_WAIT : TX_LOAD;
      default: w_next = IDLE;
    endcase
  end
  // frame capture, opcode effects, error counting and watchdog
  always_ff @(posedge clk) begin
    if (rst) begin
      r_frame <= '0;
      r_tx_data <= '0;
      r_shadow <= '0;
      r_ctrl <= '0;
      r_ctrl_update <= 1'b0;
      r_err <= '0;
      r_wd_exp <= 1'b0;
      r_wd_cnt <= '0;
    end else begin
      r_ctrl_update <= 1'b0;
      if (rx_valid && r_state == IDLE) r_frame <= rx_data;
      if (w_dec && w_read) r_tx_data <= w_rd_data;
      if (w_dec)
        case (w_op)
          4'h2: r_shadow[11:0] <= r_frame[11:0];
          4'h3: r_shadow[19:12] <= r_frame[7:0];
          4'h4: r_shadow[28:27] <= r_frame[1:0];
          4'h5: r_shadow[30:29] <= r_frame[1:0];
          4'h6: r_shadow[31] <= r_frame[0];
          default: ;
        endcase
      r_err <= w_err_sum[8] ? 8'hFF : w_err_sum[7:0];
      r_wd_cnt <= (rx_valid || w_commit) ? '0 : r_wd_cnt == WD_W'(WD_CYCLES) ? r_wd_cnt : r_wd_cnt + 1'b1;
      if (w_commit) begin
        r_ctrl <= r_shadow;
        r_ctrl_update <= 1'b1;
        r_wd_exp <= 1'b0;
      end else if (w_trip) begin
        r_ctrl[31] <= 1'b0;
        r_shadow[31] <= 1'b0;
        r_wd_exp <= 1'b1;
        r_ctrl_update <= 1'b1;
      end
    end
  end
endmodule
